meta_sqrt: RTL and testbench

- Iterative integer square root: the inverse of the squaring multiplier in the ThresholdCutter square path.
- Recovers magnitude from squared energy/threshold values: root = floor(sqrt(radicand)), remainder = radicand - root^2.
- Digit-by-digit restoring algorithm, one result bit per clock, start/done handshake.
- Radicand width is 2*OP_WIDTH, matching the multiplier result width, so multiplier output feeds it directly.

---
 rtl/meta_sqrt.sv | 90 +++++++++
 tb/tb_meta_sqrt.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/meta_sqrt.sv
// Iterative unsigned integer square root: floor(sqrt(radicand)) plus remainder,
// one root bit per clock using the digit-by-digit restoring method.
module meta_sqrt #(
  parameter int OP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2*OP_WIDTH-1:0]   radicand,
  output logic                    busy,
  output logic                    done,
  output logic [OP_WIDTH-1:0]     root,
  output logic [OP_WIDTH:0]       remainder
);

  // Handshake: start is sampled only while busy is low; the edge that accepts it
  // captures radicand. done pulses for one cycle with root/remainder already valid,
  // and those outputs hold until the next done pulse.

  localparam int RAD_WIDTH = 2 * OP_WIDTH;
  localparam int ACC_WIDTH = OP_WIDTH + 2;
  localparam int CNT_WIDTH = $clog2(OP_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(OP_WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state;
  logic [RAD_WIDTH-1:0] shreg;
  logic [ACC_WIDTH-1:0] acc;
  logic [OP_WIDTH-1:0]  q;
  logic [CNT_WIDTH-1:0] cnt;

  logic [ACC_WIDTH-1:0] acc_sh;
  logic [ACC_WIDTH-1:0] trial;
  logic [ACC_WIDTH-1:0] acc_diff;
  logic                 fits;

  // One restoring step: bring in the next two radicand bits, try subtracting 4q+1.
  always_comb begin
    acc_sh   = (acc << 2) | ACC_WIDTH'(shreg[RAD_WIDTH-1 -: 2]);
    trial    = {q, 2'b01};
    fits     = (acc_sh >= trial);
    acc_diff = acc_sh - trial;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      acc       <= '0;
      q         <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      root      <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg <= radicand;
            acc   <= '0;
            q     <= '0;
            cnt   <= CNT_INIT;
            state <= CALC;
          end
        end
        CALC: begin
          shreg <= shreg << 2;
          acc   <= fits ? acc_diff : acc_sh;
          q     <= {q[OP_WIDTH-2:0], fits};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          root      <= q;
          remainder <= acc[OP_WIDTH:0];
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_meta_sqrt.sv
// Directed and randomized checks of meta_sqrt against a real-arithmetic isqrt model.
module tb_meta_sqrt;

  localparam int OW = 16;
  localparam int RW = 2 * OW;
  localparam int N_RAND = 2000;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [RW-1:0] radicand;
  logic          busy;
  logic          done;
  logic [OW-1:0] root;
  logic [OW:0]   remainder;

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  meta_sqrt #(.OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .radicand(radicand),
    .busy(busy), .done(done), .root(root), .remainder(remainder)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor(sqrt) via real arithmetic, corrected to the exact integer.
  task automatic model(input logic [63:0] rad, output logic [63:0] r, output logic [63:0] rem);
    int ri;
    ri = $rtoi($sqrt(real'(rad)));
    r = 64'(ri);
    while (r * r > rad) r = r - 1;
    while ((r + 1) * (r + 1) <= rad) r = r + 1;
    rem = rad - r * r;
  endtask

  // driver: one start pulse, wait for done, check latency, busy length and result
  task automatic run_job(input logic [RW-1:0] rad, input string tag);
    int cyc;
    int busy_cyc;
    logic [63:0] er, erem;
    model(64'(rad), er, erem);
    @(negedge clk);
    radicand = rad;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    radicand = $urandom;
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(OW + 1));
    check({tag, "_busy_len"}, 64'(busy_cyc), 64'(OW + 1));
    check({tag, "_root"}, 64'(root), er);
    check({tag, "_rem"}, 64'(remainder), erem);
  endtask

  initial begin
    int k;
    int cyc;
    int n_done;
    logic [RW-1:0] rad;
    logic [RW-1:0] got_rad;
    logic [63:0] er, erem, r64;

    rst_n = 1'b0;
    start = 1'b0;
    radicand = '0;
    #23;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_root", 64'(root), 64'd0);
    check("reset_rem", 64'(remainder), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(32'h0000_0000, "zero");
    check("zero_root_const", 64'(root), 64'h0);
    run_job(32'h014B_5A90, "sq1234");
    check("sq1234_root_const", 64'(root), 64'h1234);
    run_job(32'h0000_0011, "r17");
    check("r17_rem_const", 64'(remainder), 64'h1);
    run_job(32'hFFFF_FFFF, "allones");
    check("allones_rem_const", 64'(remainder), 64'h1FFFE);
    run_job(32'hFFFE_0001, "sqffff");

    // start pulses during CALC and during the DONE cycle must be ignored
    @(negedge clk);
    radicand = 32'h0000_0064;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    radicand = 32'h0000_0019;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
      start = (k == 5 || k == OW) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("ignore_latency", 64'(k), 64'(OW + 1));
    check("ignore_root", 64'(root), 64'hA);
    check("ignore_rem", 64'(remainder), 64'h0);
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("ignore_extra_done", 64'(n_done), 64'd0);
    check("ignore_hold_root", 64'(root), 64'hA);
    check("ignore_idle_busy", 64'(busy), 64'd0);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    radicand = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_root", 64'(root), 64'h0);
    check("midrst_rem", 64'(remainder), 64'h0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    run_job(32'h0000_0090, "after_rst");
    check("after_rst_root_const", 64'(root), 64'hC);

    // random sweep with start held high: back-to-back jobs, 18-cycle spacing
    @(negedge clk);
    rad = $urandom;
    radicand = rad;
    exp_q.push_back(rad);
    start = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      @(posedge clk); #1;
      radicand = $urandom;
      cyc = 0;
      while (!done && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("sweep_spacing", 64'(cyc + 1), 64'(OW + 2));
      got_rad = exp_q.pop_front();
      model(64'(got_rad), er, erem);
      r64 = 64'(root);
      check("sweep_root", r64, er);
      check("sweep_rem", 64'(remainder), erem);
      check("sweep_lower", 64'(r64 * r64 <= 64'(got_rad)), 64'd1);
      check("sweep_upper", 64'((r64 + 1) * (r64 + 1) > 64'(got_rad)), 64'd1);
      if (i < N_RAND - 1) begin
        if (i % 4 == 1) begin
          r64 = 64'($urandom_range(0, 16'hFFFF));
          rad = RW'(r64 * r64);
        end else if (i % 4 == 3) begin
          r64 = 64'($urandom_range(1, 16'hFFFF));
          rad = RW'(r64 * r64 - 1);
        end else begin
          rad = $urandom;
        end
        radicand = rad;
        exp_q.push_back(rad);
      end else begin
        start = 1'b0;
      end
    end
    check("sweep_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
